// File: rtl/mmio_console_if.sv
// mmio_console_if -- dmem-side request/response bundle for the console block.
//   addr      byte address of the request
//   data_i    write data
//   data_en   request valid this cycle
//   write_en  qualifies data_en as a write (else a read)
//   data_o    registered read data, valid the cycle after a read
// master: the requester (core / bench); slave: the console.
interface mmio_console_if;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic        data_en;
  logic        write_en;
  logic [31:0] data_o;

  modport master (output addr, data_i, data_en, write_en, input data_o);
  modport slave  (input addr, data_i, data_en, write_en, output data_o);
endinterface

// File: rtl/mmio_console.sv
// mmio_console -- memory-mapped UART transmitter with a byte FIFO and an
// optional simulation-exit register.
//
// Register window (word offsets from BASE_ADDR):
//   +0 TXDATA  W: push data_i[7:0] into the TX FIFO; R: 0
//   +4 STATUS  R: {count[14:8], tx_busy[3], overflow[2], full[1], empty[0]}
//              W: data_i[2]=1 clears overflow
//   +8 EXIT    only with CONSOLE_EXIT_EN defined: writing 32'h600d600d sets
//              done until reset; reads {31'b0, done}. Otherwise unmapped.
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high
//   bus    mmio_console_if.slave request/response bundle
//   tx     UART serial line, idles high, 8N1, LSB first
//   done   sticky exit flag (tied 0 without CONSOLE_EXIT_EN)
module mmio_console #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic            clk,
  input  logic            reset,
  mmio_console_if.slave   bus,
  output logic            tx,
  output logic            done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- decode ----------------
  logic [29:0] word, base_w;
  logic        sel_tx, sel_st, sel_ex, wr, rd;

  assign word   = bus.addr[31:2];
  assign base_w = BASE_ADDR[31:2];
  assign sel_tx = (word == base_w);
  assign sel_st = (word == base_w + 30'd1);
  assign sel_ex = (word == base_w + 30'd2);
  assign wr     = bus.data_en &  bus.write_en;
  assign rd     = bus.data_en & ~bus.write_en;

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, pop, push_req, push_ok, ovf;
  state_t        state, state_n;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop      = (state == IDLE) && !empty;
  assign push_req = wr & sel_tx;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push_ok  = push_req & (!full | pop);

  // Storage is not reset: pointers/count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.data_i[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      // Set has priority over a same-cycle clear.
      if (push_req && !push_ok)                  ovf <= 1'b1;
      else if (wr && sel_st && bus.data_i[2])    ovf <= 1'b0;
    end
  end

  // ---------------- transmitter ----------------
  logic [15:0] cyc, cyc_n;
  logic [2:0]  bitcnt, bit_n;
  logic [7:0]  shreg, sh_n;
  logic        bit_end;

  assign bit_end = (cyc == 16'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cyc    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      state  <= state_n;
      cyc    <= cyc_n;
      bitcnt <= bit_n;
      shreg  <= sh_n;
    end
  end

  // tx decodes straight from state so an async reset returns the line high
  // without waiting for a clock.
  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    bit_n   = bitcnt;
    sh_n    = shreg;
    tx      = 1'b1;
    case (state)
      IDLE: begin
        if (pop) begin
          state_n = START;
          sh_n    = mem[rd_ptr];
          cyc_n   = '0;
          bit_n   = '0;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) begin
          cyc_n   = '0;
          state_n = DATA;
        end else cyc_n = cyc + 16'd1;
      end
      DATA: begin
        tx = shreg[0];
        if (bit_end) begin
          cyc_n = '0;
          sh_n  = {1'b0, shreg[7:1]};
          if (bitcnt == 3'd7) state_n = STOP;
          else                bit_n   = bitcnt + 3'd1;
        end else cyc_n = cyc + 16'd1;
      end
      STOP: begin
        if (bit_end) begin
          cyc_n   = '0;
          state_n = IDLE;
        end else cyc_n = cyc + 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------- read path ----------------
  logic [31:0] status, rdata;

  assign status = {17'b0, 7'(count), 4'b0, (state != IDLE), ovf, full, empty};

`ifdef CONSOLE_EXIT_EN
  logic done_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          done_q <= 1'b0;
    else if (wr && sel_ex && bus.data_i == 32'h600d600d) done_q <= 1'b1;
  end
  assign done = done_q;

  logic unused;
  assign unused = ^bus.addr[1:0];
`else
  assign done = 1'b0;

  logic unused;
  assign unused = ^{bus.addr[1:0], bus.data_i[31:8], sel_ex};
`endif

  // Zero by default so data_o only carries a value after a mapped read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else begin
      rdata <= '0;
      if (rd && sel_st) rdata <= status;
`ifdef CONSOLE_EXIT_EN
      if (rd && sel_ex) rdata <= {31'b0, done_q};
`endif
    end
  end

  assign bus.data_o = rdata;

endmodule

// File: tb/tb_mmio_console.sv
module tb_mmio_console;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          CPB  = 16;
`ifdef CONSOLE_EXIT_EN
  localparam logic [31:0] EXIT = 32'd1;
`else
  localparam logic [31:0] EXIT = 32'd0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx, done;
  logic [31:0] q;
  int checks = 0;
  int errors = 0;

  mmio_console_if bus();

  mmio_console #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // All bus tasks start at a negedge and consume exactly one rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.data_i = d; bus.data_en = 1'b1; bus.write_en = 1'b1;
    @(negedge clk);
    bus.data_en = 1'b0; bus.write_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    bus.addr = a; bus.data_en = 1'b1; bus.write_en = 1'b0;
    @(negedge clk);
    bus.data_en = 1'b0;
    r = bus.data_o;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called right after the TXDATA write; the frame starts one edge later.
  task automatic check_frame(input string tag, input logic [7:0] d);
    logic exp;
    int b;
    for (int c = 0; c < 10*CPB; c++) begin
      @(negedge clk);
      b = c / CPB;
      exp = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
      if ((c % CPB) == 0 || (c % CPB) == CPB-1)
        chk($sformatf("%s_bit%0d_c%0d", tag, b, c % CPB), {31'b0, tx}, {31'b0, exp});
    end
    @(negedge clk);
    chk({tag, "_after"}, {31'b0, tx}, 32'd1);
  endtask

  initial begin
    int lows;
    bus.addr = '0; bus.data_i = '0; bus.data_en = 1'b0; bus.write_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_tx",   {31'b0, tx},   32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_do",   bus.data_o,    32'd0);
    @(negedge clk) reset = 1'b0;

    // first cycle after release is already serviced
    rd(BASE + 4, q);  chk("st_reset", q, 32'h1);

    wr(BASE, 32'h41);
    check_frame("frame41", 8'h41);
    rd(BASE, q);        chk("txdata_rd", q, 32'h0);
    rd(BASE + 4, q);    chk("st_after41", q, 32'h1);
    idle(1);            chk("do_clear", bus.data_o, 32'h0);
    rd(BASE + 12, q);   chk("unmapped_c", q, 32'h0);

    // fresh reset for a known cycle reference: next edge is P0
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 9; i++) wr(BASE, 32'h10 + i);   // P0..P8, pop at P1
    rd(BASE + 4, q);    chk("st_full", q, 32'h80A);     // P9
    wr(BASE, 32'h19);                                   // P10, dropped
    rd(BASE + 4, q);    chk("st_ovf", q, 32'h80E);      // P11
    wr(BASE + 4, 32'h4);                                // P12 clear
    rd(BASE + 4, q);    chk("st_ovf_clr", q, 32'h80A);  // P13
    rd(BASE + 32'h10, q); chk("unmapped_10", q, 32'h0); // P14

    // frame of 0x10 ran P1..P161; IDLE for one cycle, pop at P162
    idle(147);
    chk("stop_gap", {31'b0, tx}, 32'd1);
    wr(BASE, 32'h1A);                                   // P162 push+pop
    chk("start2", {31'b0, tx}, 32'd0);
    rd(BASE + 4, q);    chk("st_push_pop", q, 32'h80A); // P163

    // byte 0x11: DATA bit3 spans P226..P241
    idle(70);
    chk("bit3_pre", {31'b0, tx}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_tx", {31'b0, tx}, 32'd1);
    chk("rst_mid_do", bus.data_o, 32'd0);
    @(negedge clk) reset = 1'b0;
    rd(BASE + 4, q);    chk("st_post_rst", q, 32'h1);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("no_frame", lows, 0);

    // exit register
    wr(BASE + 8, 32'h600d600c);
    chk("done_bad_val", {31'b0, done}, 32'd0);
    rd(BASE + 8, q);    chk("exit_rd0", q, 32'h0);
    wr(BASE + 8, 32'h600d600d);
    chk("done_set", {31'b0, done}, EXIT);
    rd(BASE + 8, q);    chk("exit_rd1", q, EXIT);
    idle(3);
    chk("done_sticky", {31'b0, done}, EXIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end
endmodule
